// File: rtl/key_debounce_pkg.sv
// ---------------------------------------------------------------------------
// key_debounce_pkg
// Shared types and constants for the push-button debouncer.
//   debounce_state_t        : filter FSM states (STABLE, COUNTING)
//   DEFAULT_DEBOUNCE_CYCLES : 20 ms of stable input at 50 MHz
//   KEY_PRESSED / KEY_RELEASED : active-low key levels
// ---------------------------------------------------------------------------
package key_debounce_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } debounce_state_t;

    localparam int   DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam logic KEY_PRESSED             = 1'b0;
    localparam logic KEY_RELEASED            = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser that brings an asynchronous level into the clk
// domain. Both flops load RESET_VALUE on a synchronous active-low reset.
// Used for any asynchronous input, not only keys.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low reset
//   d     : asynchronous input level
//   q     : synchronised level (two clocks of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // The first flop may go metastable; the second gives it a full clock
    // period to resolve before anything downstream looks at it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Single-channel push-button debouncer. The raw key level is synchronised
// and key_out only follows it once the synchronised level has differed from
// key_out for DEBOUNCE_CYCLES consecutive clocks. Keys are active-low.
// Optional feature macro: KEY_DEBOUNCE_EDGE_EN adds key_press / key_release
// single-cycle pulses, registered alongside key_out.
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous, active-low reset
//   key_in      : raw asynchronous button level (0 = pressed)
//   key_out     : debounced, registered level
//   key_press   : (KEY_DEBOUNCE_EDGE_EN) pulse when key_out goes 1->0
//   key_release : (KEY_DEBOUNCE_EDGE_EN) pulse when key_out goes 0->1
// ---------------------------------------------------------------------------
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic IDLE_LEVEL      = KEY_RELEASED
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_out
`ifdef KEY_DEBOUNCE_EDGE_EN
    ,
    output logic key_press,
    output logic key_release
`endif
);

    localparam int             CNT_W      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync2;
    logic [CNT_W-1:0] counter;
    debounce_state_t  state;

    // Synchroniser starts at the idle level so a reset never looks like a
    // key event to the filter.
    sync_2ff #(
        .RESET_VALUE (IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_in),
        .q     (sync2)
    );

    // Filter FSM. STABLE waits for the synchronised level to disagree with
    // key_out; COUNTING requires that disagreement to persist for
    // DEBOUNCE_CYCLES consecutive clocks (the entering cycle counts as 1).
    // Any agreeing cycle during COUNTING is a bounce and drops back to
    // STABLE, so the count restarts on the next disagreeing cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= STABLE;
            counter     <= '0;
            key_out     <= IDLE_LEVEL;
`ifdef KEY_DEBOUNCE_EDGE_EN
            key_press   <= 1'b0;
            key_release <= 1'b0;
`endif
        end else begin
`ifdef KEY_DEBOUNCE_EDGE_EN
            key_press   <= 1'b0;
            key_release <= 1'b0;
`endif
            case (state)
                STABLE: begin
                    if (sync2 != key_out) begin
                        counter <= CNT_ONE;
                        state   <= COUNTING;
                    end else begin
                        counter <= '0;
                    end
                end
                COUNTING: begin
                    if (sync2 == key_out) begin
                        counter <= '0;
                        state   <= STABLE;
                    end else if (counter == CNT_LAST) begin
                        key_out <= sync2;
                        counter <= '0;
                        state   <= STABLE;
`ifdef KEY_DEBOUNCE_EDGE_EN
                        key_press   <= (sync2 == KEY_PRESSED);
                        key_release <= (sync2 == KEY_RELEASED);
`endif
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end
                default: begin
                    counter <= '0;
                    state   <= STABLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce
// Self-checking bench for key_debounce with DEBOUNCE_CYCLES = 8. A
// behavioural model tracks how long the synchronised key has disagreed with
// the debounced level; directed scenarios pin the 10-edge latency and the
// glitch/reset behaviour, then a randomized phase exercises the rest.
// Build with KEY_DEBOUNCE_EDGE_EN to also check key_press / key_release.
// ---------------------------------------------------------------------------
module tb_key_debounce;

    localparam int D       = 8;
    localparam int LATENCY = D + 2;

    logic clk;
    logic reset;
    logic key_in;
    logic key_out;
`ifdef KEY_DEBOUNCE_EDGE_EN
    logic key_press;
    logic key_release;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;

    // Behavioural model state
    logic mS1, mS2, mOut, mPress, mRelease;
    int   mRun;

    key_debounce #(
        .DEBOUNCE_CYCLES (D),
        .IDLE_LEVEL      (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_in      (key_in),
        .key_out     (key_out)
`ifdef KEY_DEBOUNCE_EDGE_EN
        ,
        .key_press   (key_press),
        .key_release (key_release)
`endif
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic comparison: counts every check and reports mismatches
    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive key_in to a level and hold it for a number of clocks
    task automatic applyStimulus(input logic level, input int cycles);
        key_in = level;
        repeat (cycles) @(negedge clk);
    endtask

    // Drive key_in to a level and count rising edges until key_out follows.
    // Returns -1 if it never does within a generous bound.
    task automatic measureEdges(input logic level, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        key_in = level;
        for (int i = 0; i < 4 * LATENCY; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (key_out == level) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) n = -1;
`ifdef KEY_DEBOUNCE_EDGE_EN
        if (seen) begin
            checkOutput("key_press at change",   int'(key_press),   int'(level == 1'b0));
            checkOutput("key_release at change", int'(key_release), int'(level == 1'b1));
            @(posedge clk);
            #1;
            checkOutput("key_press one cycle",   int'(key_press),   0);
            checkOutput("key_release one cycle", int'(key_release), 0);
        end
`endif
        @(negedge clk);
    endtask

    // Reference model: key_out follows the twice-delayed key level once that
    // level has disagreed with key_out on D consecutive rising edges.
    always @(posedge clk) begin
        if (!reset) begin
            mS1 = 1'b1; mS2 = 1'b1; mOut = 1'b1;
            mRun = 0; mPress = 1'b0; mRelease = 1'b0;
        end else begin
            mPress = 1'b0;
            mRelease = 1'b0;
            mRun = (mS2 != mOut) ? mRun + 1 : 0;
            if (mRun == D) begin
                mOut     = mS2;
                mRun     = 0;
                mPress   = (mS2 == 1'b0);
                mRelease = (mS2 == 1'b1);
            end
            mS2 = mS1;
            mS1 = key_in;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("key_out vs model", int'(key_out), int'(mOut));
`ifdef KEY_DEBOUNCE_EDGE_EN
            checkOutput("key_press vs model",   int'(key_press),   int'(mPress));
            checkOutput("key_release vs model", int'(key_release), int'(mRelease));
`endif
        end
    end

    // Watchdog so the bench always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        testsFailed++;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        bit  sawLow;
        int  hold;

        // Reset held with the key pressed
        reset  = 1'b0;
        key_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset key_out", int'(key_out), 1);
        checkOutput("reset model",   int'(mOut),    1);
`ifdef KEY_DEBOUNCE_EDGE_EN
        checkOutput("reset key_press",   int'(key_press),   0);
        checkOutput("reset key_release", int'(key_release), 0);
`endif
        checkEn = 1'b1;

        // Release reset while still pressed: key_out falls 10 edges later
        reset = 1'b1;
        measureEdges(1'b0, n);
        checkOutput("press through reset latency", n, LATENCY);

        // Release, clean press, release
        measureEdges(1'b1, n);
        checkOutput("release latency", n, LATENCY);
        applyStimulus(1'b1, 4);
        measureEdges(1'b0, n);
        checkOutput("clean press latency", n, LATENCY);
        applyStimulus(1'b0, 4);
        measureEdges(1'b1, n);
        checkOutput("second release latency", n, LATENCY);
        applyStimulus(1'b1, 4);

        // Bounce: toggle every 3 cycles for 30 cycles, then settle pressed
        for (int i = 0; i < 10; i++) applyStimulus(i[0], 3);
        checkOutput("key_out during bounce", int'(key_out), 1);
        measureEdges(1'b0, n);
        checkOutput("press after bounce latency", n, LATENCY);
        measureEdges(1'b1, n);
        checkOutput("release after bounce latency", n, LATENCY);
        applyStimulus(1'b1, 4);

        // Short glitch of D-1 cycles must never reach key_out
        sawLow = 1'b0;
        key_in = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i == D - 1) key_in = 1'b1;
            @(negedge clk);
            if (key_out == 1'b0) sawLow = 1'b1;
        end
        checkOutput("short glitch suppressed", int'(sawLow), 0);

        // Reset mid-count discards the pending press
        applyStimulus(1'b0, 5);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid-count reset key_out", int'(key_out), 1);
        reset = 1'b1;
        measureEdges(1'b0, n);
        checkOutput("press after mid-count reset", n, LATENCY);

        // Randomized phase: mixed short bounces, long holds and rare resets
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20))
                                               : int'($urandom_range(1, 6));
            applyStimulus(1'($urandom_range(0, 1)), hold);
        end

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
